// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send,
// shifts a command byte with odd parity on device clock edges and checks the acknowledge.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       kclk,
    input  logic       kdata,
    output logic       kclk_drive_low,
    output logic       kdata_drive_low,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_RTS     = 3'd2;
    localparam logic [2:0] S_SHIFT   = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]            r_kclk_sync;
    logic [1:0]            r_kdata_sync;
    logic [FILTER_LEN-1:0] r_kclk_win;
    logic [FILTER_LEN-1:0] r_kdata_win;
    logic                  r_kclk_f;
    logic                  r_kdata_f;
    logic                  r_kclk_f_d;

    logic [2:0]       r_state;
    logic [7:0]       r_data;
    logic             r_parity;
    logic [3:0]       r_bitcnt;
    logic [INH_W-1:0] r_inh;
    logic [TO_W-1:0]  r_to;
    logic             r_dlow;
    logic             r_done;
    logic             r_err;

    logic w_fall;
    logic w_timeout;
    logic w_timed;

    // Filtered lines only change after FILTER_LEN identical synchronized samples
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_kclk_sync  <= '1;
            r_kdata_sync <= '1;
            r_kclk_win   <= '1;
            r_kdata_win  <= '1;
            r_kclk_f     <= 1'b1;
            r_kdata_f    <= 1'b1;
            r_kclk_f_d   <= 1'b1;
        end else begin
            r_kclk_sync  <= {r_kclk_sync[0], kclk};
            r_kdata_sync <= {r_kdata_sync[0], kdata};
            r_kclk_win   <= {r_kclk_win[FILTER_LEN-2:0], r_kclk_sync[1]};
            r_kdata_win  <= {r_kdata_win[FILTER_LEN-2:0], r_kdata_sync[1]};
            if (&r_kclk_win)
                r_kclk_f <= 1'b1;
            else if (~|r_kclk_win)
                r_kclk_f <= 1'b0;
            if (&r_kdata_win)
                r_kdata_f <= 1'b1;
            else if (~|r_kdata_win)
                r_kdata_f <= 1'b0;
            r_kclk_f_d <= r_kclk_f;
        end
    end

    assign w_fall    = r_kclk_f_d & ~r_kclk_f;
    assign w_timed   = (r_state == S_SHIFT) || (r_state == S_ACK) || (r_state == S_RELEASE);
    // Fires so that tx_error lands TIMEOUT_CYCLES cycles after the last detected edge
    assign w_timeout = (r_to == TO_W'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_data   <= '0;
            r_parity <= 1'b0;
            r_bitcnt <= '0;
            r_inh    <= '0;
            r_to     <= '0;
            r_dlow   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_timed)
                r_to <= w_fall ? '0 : r_to + TO_W'(1);
            case (r_state)
                S_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        r_data   <= tx_data;
                        r_parity <= ~^tx_data;
                        r_inh    <= '0;
                        r_state  <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (r_inh == INH_W'(INHIBIT_CYCLES - 1))
                        r_state <= S_RTS;
                    else
                        r_inh <= r_inh + INH_W'(1);
                end
                S_RTS: begin
                    r_dlow   <= 1'b1;
                    r_bitcnt <= '0;
                    r_to     <= '0;
                    r_state  <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (w_fall) begin
                        r_bitcnt <= r_bitcnt + 4'd1;
                        if (r_bitcnt < 4'd8)
                            r_dlow <= ~r_data[r_bitcnt[2:0]];
                        else if (r_bitcnt == 4'd8)
                            r_dlow <= ~r_parity;
                        else begin
                            r_dlow  <= 1'b0;
                            r_state <= S_ACK;
                        end
                    end else if (w_timeout) begin
                        r_dlow  <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_ACK: begin
                    if (w_fall) begin
                        if (!r_kdata_f)
                            r_state <= S_RELEASE;
                        else begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_RELEASE: begin
                    if (r_kclk_f && r_kdata_f) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Line drives decode straight from state so reset releases them without waiting for a clock
    assign kclk_drive_low  = (r_state == S_INHIBIT) || (r_state == S_RTS);
    assign kdata_drive_low = (r_state == S_RTS) || ((r_state == S_SHIFT) && r_dlow);
    assign tx_ready        = (r_state == S_IDLE) && !r_done && !r_err;
    assign busy            = (r_state != S_IDLE);
    assign tx_done         = r_done;
    assign tx_error        = r_err;

endmodule
